// File: rtl/link_train_sequencer_if.sv
// Control/status bundle between the lane sequencer and the RX IOD, bit-align core and PRBS checker.
interface link_train_sequencer_if;
  localparam int unsigned RETRY_W = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned ERR_W   = 16;

  logic               EN;
  logic               PLL_LOCK;
  logic               CLK_TRAIN_DONE;
  logic               CLK_TRAIN_ERROR;
  logic               BIT_ALGN_DONE;
  logic               BIT_ALGN_ERR;
  logic               BIT_ALGN_OOR;
  logic               PRBS_ERR;
  logic               RX_CLK_TRAIN_RESTART;
  logic               BIT_ALGN_RSTRT;
  logic               LINK_UP;
  logic               LINK_FAIL;
  logic [RETRY_W-1:0] RETRY_CNT;
  logic [STATE_W-1:0] STATE;
  logic [ERR_W-1:0]   ERR_CNT;

  modport slave (
    input  EN, PLL_LOCK, CLK_TRAIN_DONE, CLK_TRAIN_ERROR,
           BIT_ALGN_DONE, BIT_ALGN_ERR, BIT_ALGN_OOR, PRBS_ERR,
    output RX_CLK_TRAIN_RESTART, BIT_ALGN_RSTRT, LINK_UP, LINK_FAIL,
           RETRY_CNT, STATE, ERR_CNT
  );

  modport master (
    output EN, PLL_LOCK, CLK_TRAIN_DONE, CLK_TRAIN_ERROR,
           BIT_ALGN_DONE, BIT_ALGN_ERR, BIT_ALGN_OOR, PRBS_ERR,
    input  RX_CLK_TRAIN_RESTART, BIT_ALGN_RSTRT, LINK_UP, LINK_FAIL,
           RETRY_CNT, STATE, ERR_CNT
  );
endinterface

// File: rtl/link_train_sequencer.sv
// RX lane bring-up sequencer: PLL lock wait, clock training, bit alignment, PRBS soak, retry/fail.
// Optional: define LINK_AUTO_RETRAIN_EN to retrain after the 16th PRBS error in LINK_UP.
module link_train_sequencer #(
  parameter int unsigned LOCK_WAIT     = 1024,
  parameter int unsigned TRAIN_TIMEOUT = 65535,
  parameter int unsigned SOAK_CYCLES   = 4096,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned RSTRT_LEN     = 4,
  parameter int unsigned TMR_W         = 20
) (
  input  logic                   SCLK,
  input  logic                   RESETN,
  link_train_sequencer_if.slave  bus
);

  localparam int unsigned RETRY_W = 8;
  localparam int unsigned ERR_W   = 16;

  localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_WAIT - 1);
  localparam logic [TMR_W-1:0]   TRAIN_LAST  = TMR_W'(TRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   SOAK_LAST   = TMR_W'(SOAK_CYCLES - 1);
  localparam logic [TMR_W-1:0]   PULSE_LEN   = TMR_W'(RSTRT_LEN);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [ERR_W-1:0]   ERR_SAT     = '1;
`ifdef LINK_AUTO_RETRAIN_EN
  localparam logic [ERR_W-1:0]   RETRAIN_THR = ERR_W'(15);
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CLK_TRAIN = 3'd2,
    ST_BIT_ALIGN = 3'd3,
    ST_SOAK      = 3'd4,
    ST_LINK_UP   = 3'd5,
    ST_RETRY     = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               clk_rst_q, clk_rst_d;
  logic               ba_rst_q, ba_rst_d;
  logic               up_q, up_d;
  logic               fail_q, fail_d;
  logic               pulse_done;
  logic               lock_lost;

  // Done/error levels only count once the restart pulse has finished.
  assign pulse_done = (timer_q >= PULSE_LEN);
  assign lock_lost  = !bus.PLL_LOCK;

  // State, timer, counters and registered outputs.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      clk_rst_q <= 1'b0;
      ba_rst_q  <= 1'b0;
      up_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      clk_rst_q <= clk_rst_d;
      ba_rst_q  <= ba_rst_d;
      up_q      <= up_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state, timer and next-output logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    retry_d   = retry_q;
    err_d     = err_q;
    clk_rst_d = 1'b0;
    ba_rst_d  = 1'b0;
    up_d      = 1'b0;
    fail_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.EN) begin
          state_d = ST_WAIT_LOCK;
          retry_d = '0;
          err_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.PLL_LOCK && (timer_q == LOCK_LAST)) state_d = ST_CLK_TRAIN;
      end
      ST_CLK_TRAIN: begin
        if (lock_lost)                                state_d = ST_RETRY;
        else if (pulse_done && bus.CLK_TRAIN_ERROR)   state_d = ST_RETRY;
        else if (pulse_done && bus.CLK_TRAIN_DONE)    state_d = ST_BIT_ALIGN;
        else if (timer_q == TRAIN_LAST)               state_d = ST_RETRY;
      end
      ST_BIT_ALIGN: begin
        if (lock_lost)                                             state_d = ST_RETRY;
        else if (pulse_done && (bus.BIT_ALGN_ERR || bus.BIT_ALGN_OOR)) state_d = ST_RETRY;
        else if (pulse_done && bus.BIT_ALGN_DONE)                  state_d = ST_SOAK;
        else if (timer_q == TRAIN_LAST)                            state_d = ST_RETRY;
      end
      ST_SOAK: begin
        if (lock_lost || bus.PRBS_ERR) state_d = ST_RETRY;
        else if (timer_q == SOAK_LAST) state_d = ST_LINK_UP;
      end
      ST_LINK_UP: begin
        if (bus.PRBS_ERR && (err_q != ERR_SAT)) err_d = err_q + 1'b1;
        if (lock_lost) state_d = ST_RETRY;
`ifdef LINK_AUTO_RETRAIN_EN
        else if (bus.PRBS_ERR && (err_q >= RETRAIN_THR)) state_d = ST_RETRY;
`endif
      end
      ST_RETRY: begin
        if (retry_q == RETRY_MAX) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_WAIT_LOCK;
          retry_d = retry_q + 1'b1;
`ifdef LINK_AUTO_RETRAIN_EN
          err_d   = '0;
`endif
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    // Disable overrides everything and returns to a clean idle.
    if (!bus.EN) begin
      state_d = ST_IDLE;
      retry_d = '0;
      err_d   = '0;
    end

    // Timer restarts on every state change; WAIT_LOCK counts consecutive lock only.
    if (state_d == state_q) begin
      case (state_q)
        ST_WAIT_LOCK:                   timer_d = bus.PLL_LOCK ? timer_q + 1'b1 : '0;
        ST_CLK_TRAIN, ST_BIT_ALIGN,
        ST_SOAK:                        timer_d = timer_q + 1'b1;
        default:                        timer_d = '0;
      endcase
    end

    clk_rst_d = (state_d == ST_CLK_TRAIN) && (timer_d < PULSE_LEN);
    ba_rst_d  = (state_d == ST_BIT_ALIGN) && (timer_d < PULSE_LEN);
    up_d      = (state_d == ST_LINK_UP);
    fail_d    = (state_d == ST_FAIL);
  end

  assign bus.STATE                = state_q;
  assign bus.RETRY_CNT            = retry_q;
  assign bus.ERR_CNT              = err_q;
  assign bus.RX_CLK_TRAIN_RESTART = clk_rst_q;
  assign bus.BIT_ALGN_RSTRT       = ba_rst_q;
  assign bus.LINK_UP              = up_q;
  assign bus.LINK_FAIL            = fail_q;

endmodule
